pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Hazard and stall sequencer for the five-stage pipeline. It drives the write enables of the PC and IF_ID registers, the bubble (control-zero) input of ID_EX, and a global hold for ID_EX, EX_MEM and MEM_WB. It resolves three conditions:
- load-use data hazards;
- taken-branch/jump flushes;
- multi-cycle data-memory waits, with a timeout error.

It also keeps a saturating stall-cycle counter for performance monitoring.

## Interface
Parameters:
- TIMEOUT, 64: maximum consecutive memory-wait cycles before the error state; legal range ≥ 2.
- CNT_W, 16: width of the stall counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- IFID_rs_i  input  5  rs field of the instruction in ID.
- IFID_rt_i  input  5  rt field of the instruction in ID.
- IDEX_rt_i  input  5  rt (load destination) of the instruction in EX.
- IDEX_MemRead_i  input  1  instruction in EX is a load.
- branch_taken_i  input  1  branch/jump in ID resolved taken this cycle.
- dmem_req_i  input  1  instruction in MEM accesses data memory.
- dmem_ack_i  input  1  data memory completes the access this cycle.
- PC_write_o  output  1  PC register write enable.
- IFID_write_o  output  1  IF_ID register write enable.
- IFID_flush_o  output  1  load NOP into IF_ID.
- IDEX_bubble_o  output  1  zero all control fields entering ID_EX.
- pipe_hold_o  output  1  freeze ID_EX, EX_MEM, MEM_WB.
- err_o  output  1  memory timeout; sticky until reset.
- stall_cnt_o  output  CNT_W  saturating count of stall cycles.

## Operation
- FSM states: RUN, MEM_WAIT, ERR. Internal wait counter wcnt is log2(TIMEOUT)+1 bits.
- load_use = IDEX_MemRead_i and IDEX_rt_i ≠ 0 and (IDEX_rt_i == IFID_rs_i or IDEX_rt_i == IFID_rt_i). Both source fields are compared unconditionally; this is deliberately conservative.
- mem_busy = dmem_req_i and not dmem_ack_i.
- Priority in RUN or MEM_WAIT: mem_busy > load_use > branch_taken_i.
  - mem_busy: PC_write_o=0, IFID_write_o=0, pipe_hold_o=1, IDEX_bubble_o=0, IFID_flush_o=0.
  - load_use (not mem_busy): PC_write_o=0, IFID_write_o=0, IDEX_bubble_o=1, pipe_hold_o=0, IFID_flush_o=0.
  - branch_taken_i (neither of the above): IFID_flush_o=1; all enables 1; bubble 0.
  - Otherwise: PC_write_o=1, IFID_write_o=1, all other outputs 0.
- A branch suppressed by a stall is not remembered. The held ID instruction re-asserts branch_taken_i in a later cycle.
- Transitions:
  - RUN→MEM_WAIT when mem_busy; wcnt←1.
  - MEM_WAIT→RUN when dmem_ack_i; wcnt←0.
  - In MEM_WAIT with mem_busy: if wcnt == TIMEOUT−1, go to ERR; else wcnt←wcnt+1.
  - ERR persists until rst.
- ERR outputs, independent of all inputs: pipe_hold_o=1, PC_write_o=0, IFID_write_o=0, err_o=1, bubble 0, flush 0.
- stall_cnt_o increments by 1 on every clock edge at which PC_write_o==0, including in ERR. It saturates at 2^CNT_W−1 and does not wrap.

## Timing
- All hazard outputs are combinational from the current state and inputs; there is zero added latency. A zero-wait memory (dmem_ack_i high together with dmem_req_i) causes no hold.
- Hold sequence: a wait of N cycles (ack arriving N cycles after req) gives exactly N cycles of pipe_hold_o=1. The pipeline advances on the ack cycle.
- Load-use gives exactly one bubble cycle. On the next cycle the bubble sits in EX with MemRead=0, so the stall does not repeat.
- ERR is entered after TIMEOUT consecutive mem_busy cycles. err_o rises in the cycle after the TIMEOUT-th held cycle.
- Reset:
  - While rst=1, outputs are forced to PC_write_o=1, IFID_write_o=1, IFID_flush_o=0, IDEX_bubble_o=0, pipe_hold_o=0, err_o=0.
  - At the clock edge: state←RUN, wcnt←0, stall_cnt_o←0.
  - Reset during MEM_WAIT or ERR aborts the wait immediately.
- Simultaneous events:
  - dmem_ack_i in the same cycle as load_use: the bubble is inserted; no hold.
  - mem_busy together with load_use: hold only. The load-use condition is re-evaluated after the hold releases.

## Test plan
1. Load-use: IDEX_MemRead_i=1, IDEX_rt_i=8, IFID_rs_i=8 → one cycle of PC_write_o=0, IFID_write_o=0, IDEX_bubble_o=1. With IDEX_rt_i=0, or with no rs/rt match → no stall.
2. Branch flush: branch_taken_i=1 with no hazard → IFID_flush_o=1 for 1 cycle, enables stay 1. Branch together with load-use → bubble only, flush 0.
3. Memory wait: dmem_req_i=1, ack after 3 cycles → pipe_hold_o=1 for exactly 3 cycles, state returns to RUN, stall_cnt_o=3. Same-cycle ack → 0 hold cycles.
4. Timeout: TIMEOUT=4, dmem_req_i=1, ack never → err_o=1 from cycle 5. Outputs stay frozen despite later ack and branch inputs. rst=1 → RUN, err_o=0, stall_cnt_o=0.
5. Counter saturation: CNT_W=4, 20 consecutive load-use stall cycles → stall_cnt_o=15, no wrap.
6. Reset mid-wait: assert rst in the 2nd MEM_WAIT cycle → pipe_hold_o=0 in that same cycle. After release, a new req/ack pair with 1 wait cycle gives exactly 1 hold cycle.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and stall sequencer: load-use bubbles, branch flushes,
// data-memory wait holds with timeout, and a saturating stall counter.
module pipe_hazard_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       IFID_rs_i,
  input  logic [4:0]       IFID_rt_i,
  input  logic [4:0]       IDEX_rt_i,
  input  logic             IDEX_MemRead_i,
  input  logic             branch_taken_i,
  input  logic             dmem_req_i,
  input  logic             dmem_ack_i,
  output logic             PC_write_o,
  output logic             IFID_write_o,
  output logic             IFID_flush_o,
  output logic             IDEX_bubble_o,
  output logic             pipe_hold_o,
  output logic             err_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam int WW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {
    RUN,
    MEM_WAIT,
    ERR
  } state_e;

  state_e           state_q, state_d;
  logic [WW-1:0]    wcnt_q, wcnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic load_use;
  logic mem_busy;

  assign load_use = IDEX_MemRead_i && (IDEX_rt_i != 5'd0) &&
                    ((IDEX_rt_i == IFID_rs_i) ||
                     (IDEX_rt_i == IFID_rt_i));
  assign mem_busy = dmem_req_i && !dmem_ack_i;

  // Zero-latency hazard outputs; reset and ERR override the inputs.
  always_comb begin
    PC_write_o    = 1'b1;
    IFID_write_o  = 1'b1;
    IFID_flush_o  = 1'b0;
    IDEX_bubble_o = 1'b0;
    pipe_hold_o   = 1'b0;
    err_o         = 1'b0;
    if (rst) begin
      PC_write_o = 1'b1;
    end else if (state_q == ERR) begin
      PC_write_o   = 1'b0;
      IFID_write_o = 1'b0;
      pipe_hold_o  = 1'b1;
      err_o        = 1'b1;
    end else if (mem_busy) begin
      PC_write_o   = 1'b0;
      IFID_write_o = 1'b0;
      pipe_hold_o  = 1'b1;
    end else if (load_use) begin
      PC_write_o    = 1'b0;
      IFID_write_o  = 1'b0;
      IDEX_bubble_o = 1'b1;
    end else if (branch_taken_i) begin
      IFID_flush_o = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    unique case (state_q)
      RUN: begin
        if (mem_busy) begin
          state_d = MEM_WAIT;
          wcnt_d  = WW'(1);
        end
      end
      MEM_WAIT: begin
        if (!mem_busy) begin
          state_d = RUN;
          wcnt_d  = '0;
        end else if (wcnt_q == WW'(TIMEOUT - 1)) begin
          state_d = ERR;
        end else begin
          wcnt_d = wcnt_q + WW'(1);
        end
      end
      ERR: begin
        state_d = ERR;
      end
      default: begin
        state_d = RUN;
        wcnt_d  = '0;
      end
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (!PC_write_o && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      wcnt_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with TIMEOUT=4, CNT_W=4.
// Outputs packed as {pc,ifid,flush,bubble,hold,err}.
module tb_pipe_hazard_ctrl;

  localparam logic [5:0] O_RUN   = 6'b110000;
  localparam logic [5:0] O_STALL = 6'b000100;
  localparam logic [5:0] O_FLUSH = 6'b111000;
  localparam logic [5:0] O_HOLD  = 6'b000010;
  localparam logic [5:0] O_ERR   = 6'b000011;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] IFID_rs_i, IFID_rt_i, IDEX_rt_i;
  logic       IDEX_MemRead_i, branch_taken_i;
  logic       dmem_req_i, dmem_ack_i;
  logic       PC_write_o, IFID_write_o, IFID_flush_o;
  logic       IDEX_bubble_o, pipe_hold_o, err_o;
  logic [3:0] stall_cnt_o;
  logic [5:0] outs;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign outs = {PC_write_o, IFID_write_o, IFID_flush_o,
                 IDEX_bubble_o, pipe_hold_o, err_o};

  pipe_hazard_ctrl #(.TIMEOUT(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .IFID_rs_i(IFID_rs_i), .IFID_rt_i(IFID_rt_i),
    .IDEX_rt_i(IDEX_rt_i), .IDEX_MemRead_i(IDEX_MemRead_i),
    .branch_taken_i(branch_taken_i),
    .dmem_req_i(dmem_req_i), .dmem_ack_i(dmem_ack_i),
    .PC_write_o(PC_write_o), .IFID_write_o(IFID_write_o),
    .IFID_flush_o(IFID_flush_o), .IDEX_bubble_o(IDEX_bubble_o),
    .pipe_hold_o(pipe_hold_o), .err_o(err_o),
    .stall_cnt_o(stall_cnt_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    IFID_rs_i = 5'd0; IFID_rt_i = 5'd0; IDEX_rt_i = 5'd0;
    IDEX_MemRead_i = 1'b0; branch_taken_i = 1'b0;
    dmem_req_i = 1'b0; dmem_ack_i = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic set_lu(input logic [4:0] ex_rt,
                        input logic [4:0] rs,
                        input logic [4:0] rt);
    IDEX_MemRead_i = 1'b1;
    IDEX_rt_i = ex_rt; IFID_rs_i = rs; IFID_rt_i = rt;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_lu(5'd8, 5'd8, 5'd0);
    dmem_req_i = 1'b1;
    branch_taken_i = 1'b1;
    #1;
    n_cmp++;
    if (outs !== O_RUN) begin
      n_bad++;
      $display("FAIL reset_forced: got %b want %b", outs, O_RUN);
    end
    tick();
    rst = 1'b0;
    idle();
    #1;
    n_cmp++;
    if (stall_cnt_o !== 4'd0) begin
      n_bad++;
      $display("FAIL reset_cnt: got %0d want 0", stall_cnt_o);
    end
    n_cmp++;
    if (outs !== O_RUN) begin
      n_bad++;
      $display("FAIL reset_idle: got %b want %b", outs, O_RUN);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    set_lu(5'd8, 5'd8, 5'd3);
    #1;
    n_cmp++;
    if (outs !== O_STALL) begin
      n_bad++;
      $display("FAIL lu_rs: got %b want %b", outs, O_STALL);
    end
    tick();
    idle();
    #1;
    n_cmp++;
    if (outs !== O_RUN) begin
      n_bad++;
      $display("FAIL lu_once: got %b want %b", outs, O_RUN);
    end
    n_cmp++;
    if (stall_cnt_o !== 4'd1) begin
      n_bad++;
      $display("FAIL lu_cnt: got %0d want 1", stall_cnt_o);
    end
    set_lu(5'd0, 5'd0, 5'd0);
    #1;
    n_cmp++;
    if (outs !== O_RUN) begin
      n_bad++;
      $display("FAIL lu_r0: got %b want %b", outs, O_RUN);
    end
    set_lu(5'd8, 5'd3, 5'd9);
    #1;
    n_cmp++;
    if (outs !== O_RUN) begin
      n_bad++;
      $display("FAIL lu_nomatch: got %b want %b", outs, O_RUN);
    end
    set_lu(5'd17, 5'd2, 5'd17);
    #1;
    n_cmp++;
    if (outs !== O_STALL) begin
      n_bad++;
      $display("FAIL lu_rt: got %b want %b", outs, O_STALL);
    end
    IDEX_MemRead_i = 1'b0;
    #1;
    n_cmp++;
    if (outs !== O_RUN) begin
      n_bad++;
      $display("FAIL lu_noload: got %b want %b", outs, O_RUN);
    end
    idle();
  endtask

  task automatic test_branch();
    do_reset();
    branch_taken_i = 1'b1;
    #1;
    n_cmp++;
    if (outs !== O_FLUSH) begin
      n_bad++;
      $display("FAIL br_flush: got %b want %b", outs, O_FLUSH);
    end
    tick();
    branch_taken_i = 1'b0;
    #1;
    n_cmp++;
    if (outs !== O_RUN) begin
      n_bad++;
      $display("FAIL br_once: got %b want %b", outs, O_RUN);
    end
    branch_taken_i = 1'b1;
    set_lu(5'd5, 5'd5, 5'd0);
    #1;
    n_cmp++;
    if (outs !== O_STALL) begin
      n_bad++;
      $display("FAIL br_lu: got %b want %b", outs, O_STALL);
    end
    idle();
  endtask

  task automatic test_mem_wait();
    int holds;
    do_reset();
    holds = 0;
    dmem_req_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (pipe_hold_o === 1'b1) holds++;
      tick();
    end
    dmem_ack_i = 1'b1;
    #1;
    if (pipe_hold_o === 1'b1) holds++;
    n_cmp++;
    if (outs !== O_RUN) begin
      n_bad++;
      $display("FAIL mw_ack: got %b want %b", outs, O_RUN);
    end
    tick();
    idle();
    #1;
    n_cmp++;
    if (holds != 3) begin
      n_bad++;
      $display("FAIL mw_holds: got %0d want 3", holds);
    end
    n_cmp++;
    if (stall_cnt_o !== 4'd3) begin
      n_bad++;
      $display("FAIL mw_cnt: got %0d want 3", stall_cnt_o);
    end
    // state must be back in RUN: a load-use now bubbles normally
    set_lu(5'd4, 5'd4, 5'd0);
    #1;
    n_cmp++;
    if (outs !== O_STALL) begin
      n_bad++;
      $display("FAIL mw_run: got %b want %b", outs, O_STALL);
    end
    idle();
    dmem_req_i = 1'b1;
    dmem_ack_i = 1'b1;
    #1;
    n_cmp++;
    if (outs !== O_RUN) begin
      n_bad++;
      $display("FAIL mw_zero: got %b want %b", outs, O_RUN);
    end
    tick();
    idle();
    #1;
    n_cmp++;
    if (stall_cnt_o !== 4'd3) begin
      n_bad++;
      $display("FAIL mw_zero_cnt: got %0d want 3", stall_cnt_o);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    dmem_req_i = 1'b1;
    set_lu(5'd6, 5'd6, 5'd0);
    #1;
    n_cmp++;
    if (outs !== O_HOLD) begin
      n_bad++;
      $display("FAIL sim_busy_lu: got %b want %b", outs, O_HOLD);
    end
    tick();
    dmem_ack_i = 1'b1;
    #1;
    n_cmp++;
    if (outs !== O_STALL) begin
      n_bad++;
      $display("FAIL sim_ack_lu: got %b want %b", outs, O_STALL);
    end
    tick();
    idle();
    #1;
    n_cmp++;
    if (outs !== O_RUN) begin
      n_bad++;
      $display("FAIL sim_after: got %b want %b", outs, O_RUN);
    end
    n_cmp++;
    if (stall_cnt_o !== 4'd2) begin
      n_bad++;
      $display("FAIL sim_cnt: got %0d want 2", stall_cnt_o);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    dmem_req_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++;
      if (outs !== O_HOLD) begin
        n_bad++;
        $display("FAIL to_hold%0d: got %b want %b", i, outs, O_HOLD);
      end
      tick();
    end
    n_cmp++;
    if (outs !== O_ERR) begin
      n_bad++;
      $display("FAIL to_err: got %b want %b", outs, O_ERR);
    end
    dmem_ack_i = 1'b1;
    branch_taken_i = 1'b1;
    #1;
    n_cmp++;
    if (outs !== O_ERR) begin
      n_bad++;
      $display("FAIL to_frozen: got %b want %b", outs, O_ERR);
    end
    tick();
    idle();
    #1;
    n_cmp++;
    if (outs !== O_ERR) begin
      n_bad++;
      $display("FAIL to_sticky: got %b want %b", outs, O_ERR);
    end
    n_cmp++;
    if (stall_cnt_o !== 4'd5) begin
      n_bad++;
      $display("FAIL to_cnt: got %0d want 5", stall_cnt_o);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (outs !== O_RUN) begin
      n_bad++;
      $display("FAIL to_rst_out: got %b want %b", outs, O_RUN);
    end
    tick();
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({err_o, stall_cnt_o} !== 5'b0_0000) begin
      n_bad++;
      $display("FAIL to_rst: got err=%b cnt=%0d want 0/0",
               err_o, stall_cnt_o);
    end
  endtask

  task automatic test_saturation();
    int exp;
    do_reset();
    set_lu(5'd8, 5'd8, 5'd0);
    for (int i = 0; i < 20; i++) begin
      tick();
      exp = (i + 1 > 15) ? 15 : i + 1;
      n_cmp++;
      if (stall_cnt_o !== 4'(exp)) begin
        n_bad++;
        $display("FAIL sat_%0d: got %0d want %0d", i, stall_cnt_o, exp);
      end
    end
    idle();
  endtask

  task automatic test_reset_mid_wait();
    int holds;
    do_reset();
    dmem_req_i = 1'b1;
    tick();
    rst = 1'b1;
    #1;
    n_cmp++;
    if (pipe_hold_o !== 1'b0) begin
      n_bad++;
      $display("FAIL rmw_hold: got %b want 0", pipe_hold_o);
    end
    tick();
    rst = 1'b0;
    idle();
    tick();
    holds = 0;
    dmem_req_i = 1'b1;
    #1;
    if (pipe_hold_o === 1'b1) holds++;
    tick();
    dmem_ack_i = 1'b1;
    #1;
    if (pipe_hold_o === 1'b1) holds++;
    tick();
    idle();
    #1;
    n_cmp++;
    if (holds != 1) begin
      n_bad++;
      $display("FAIL rmw_holds: got %0d want 1", holds);
    end
    n_cmp++;
    if (stall_cnt_o !== 4'd1) begin
      n_bad++;
      $display("FAIL rmw_cnt: got %0d want 1", stall_cnt_o);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rst = 1'b1;
    tick();
    test_reset();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_simultaneous();
    test_timeout();
    test_saturation();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
